seg7_decoder: RTL and testbench
===============================

SEG7_DECODER -- requirements
Module: seg7_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, legal range 1..15: consecutive identical samples required before a pattern is accepted.
REQ-002 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-003 RESET_N  input  1  reset, synchronous, active-low.
REQ-004 SEG_IN  input  7  active-low segment pattern, bit 6 = g ... bit 0 = a, same encoding as HEX0 drive.
REQ-005 OUT_READY  input  1  consumer accepts the current output beat.
REQ-006 OUT_VALID  output  1  CODE/ERR hold a decoded beat.
REQ-007 CODE  output  4  decoded code.
REQ-008 ERR  output  1  beat came from an unrecognised pattern.
REQ-009 ERR_COUNT  output  8  saturating count of error beats (see Configuration).

Function
REQ-010 SEG_IN shall be registered once into a sample register before any comparison.
REQ-011 Decode table: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 1000110->A, 1000001->B, 0010001->D, 0001001->E, 1111111->F.
REQ-012 1111001 is ambiguous (1 or I); it shall always decode to 0001, never to 1100.
REQ-013 Any other pattern shall decode to CODE=0000 with ERR=1.
REQ-014 A 4-bit stability counter shall reset to 1 when the sample differs from the previous sample, else increment, saturating at STABLE_CYCLES.
REQ-015 A pattern is "stable" when the counter equals STABLE_CYCLES.
REQ-016 States: TRACK (no beat pending) and PRESENT (OUT_VALID=1).
REQ-017 TRACK->PRESENT when the pattern is stable and differs from the last emitted pattern, or no pattern has been emitted since reset; CODE/ERR load on that edge.
REQ-018 With SEG_IN settled before edge 0, OUT_VALID shall rise after edge STABLE_CYCLES+1 (1 sample + STABLE_CYCLES compares).
REQ-019 In PRESENT, CODE and ERR shall hold constant until OUT_VALID && OUT_READY at a rising edge, then return to TRACK.
REQ-020 In PRESENT, sampling and stability counting shall continue; patterns that stabilise and vanish during PRESENT are dropped.
REQ-021 After a handshake, if the currently stable pattern differs from the one just emitted, a new beat shall present on the next edge (no bubble beyond one cycle).
REQ-022 A stable pattern equal to the last emitted pattern shall never produce a second beat.
REQ-023 OUT_READY while OUT_VALID=0 shall have no effect.

Reset
REQ-024 While RESET_N=0 at a rising edge: OUT_VALID=0, CODE=0000, ERR=0, ERR_COUNT=0, counter=0, state TRACK, "emitted" flag cleared.
REQ-025 Reset during PRESENT shall discard the pending beat; no handshake is required.

Configuration
REQ-026 Macro SEG7_ERRCNT_EN defined: ERR_COUNT increments by 1 on each handshake with ERR=1, saturating at 255.
REQ-027 Macro undefined: ERR_COUNT is constant 0 and no counter registers are generated; all other behaviour is identical.

Structure
REQ-028 Package seg7_pkg shall hold the 16 segment-pattern constants and the 4-bit code type, shared with the existing 7-segment encoder.
REQ-029 Sub-module seg7_lut (combinational pattern -> code, err) shall implement REQ-011..013; the FSM, counters and handshake live in seg7_decoder.

Verification
REQ-030 Reset, then SEG_IN=0100100 held, OUT_READY=1 -> OUT_VALID rises after edge 5 with CODE=2, ERR=0, for exactly one cycle.
REQ-031 SEG_IN toggles 0110000/0011001 every 2 cycles for 20 cycles, then holds 0011001 -> no beat during toggling, then one beat with CODE=4.
REQ-032 SEG_IN=1111001, OUT_READY=0 for 10 cycles -> CODE=1 held and stable throughout; SEG_IN changes to 0000000 mid-wait, then OUT_READY=1 -> beat CODE=1 accepted, next cycle beat CODE=8.
REQ-033 SEG_IN=0101010 -> beat CODE=0, ERR=1; with SEG7_ERRCNT_EN, 300 alternating error/valid pattern handshakes -> ERR_COUNT=255; without the macro -> ERR_COUNT=0.
REQ-034 Reset asserted for one cycle while OUT_VALID=1 -> all outputs 0 next edge; same pattern held -> beat re-emitted after STABLE_CYCLES+1 edges.
REQ-035 Same pattern 1111111 held 100 cycles after handshake -> exactly one beat, CODE=F.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low patterns (bit 6 = g ... bit 0 = a),
// the 4-bit code type and the decoder FSM state type.
package seg7_pkg;

  typedef logic [3:0] code_t;
  typedef logic [6:0] seg_t;

  typedef enum logic {
    TRACK   = 1'b0,
    PRESENT = 1'b1
  } state_e;

  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_A = 7'b1000110;
  localparam seg_t SEG_B = 7'b1000001;
  // Lowercase 'c' drawn by the encoder; it is not part of the decode table
  // and therefore decodes as an unrecognised pattern.
  localparam seg_t SEG_C = 7'b0100111;
  localparam seg_t SEG_D = 7'b0010001;
  localparam seg_t SEG_E = 7'b0001001;
  localparam seg_t SEG_F = 7'b1111111;

endpackage

// File: rtl/seg7_lut.sv
// Combinational pattern -> (code, err) lookup. Unknown patterns give code 0
// with err set. 1111001 always maps to 1 (never to the look-alike 'I').
module seg7_lut
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       err
);

  // Table lookup with an error default for anything not listed
  always_comb begin
    code = 4'h0;
    err  = 1'b0;
    case (pattern)
      SEG_0:   code = 4'h0;
      SEG_1:   code = 4'h1;
      SEG_2:   code = 4'h2;
      SEG_3:   code = 4'h3;
      SEG_4:   code = 4'h4;
      SEG_5:   code = 4'h5;
      SEG_6:   code = 4'h6;
      SEG_7:   code = 4'h7;
      SEG_8:   code = 4'h8;
      SEG_9:   code = 4'h9;
      SEG_A:   code = 4'hA;
      SEG_B:   code = 4'hB;
      SEG_D:   code = 4'hD;
      SEG_E:   code = 4'hE;
      SEG_F:   code = 4'hF;
      default: err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_decoder.sv
// 7-segment pattern decoder with debounce and a valid/ready output beat.
// Optional feature: define SEG7_ERRCNT_EN to build the saturating error-beat
// counter on ERR_COUNT; otherwise ERR_COUNT is tied to zero.
//
// Handshake: OUT_VALID is high while a beat is held; CODE/ERR are frozen
// while OUT_VALID=1 and the beat is consumed at a rising edge where
// OUT_VALID && OUT_READY. OUT_READY is ignored while OUT_VALID=0.
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [6:0] SEG_IN,
  input  logic       OUT_READY,
  output logic       OUT_VALID,
  output logic [3:0] CODE,
  output logic       ERR,
  output logic [7:0] ERR_COUNT
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  // sample_q is the registered input; prev_q is the sample one cycle older.
  // The *_vld flags keep the first comparisons after reset meaningful.
  seg_t        sample_q, sample_d;
  seg_t        prev_q, prev_d;
  logic        samp_vld_q, samp_vld_d;
  logic        prev_vld_q, prev_vld_d;
  logic [3:0]  cnt_q, cnt_d;
  state_e      state_q, state_d;
  code_t       code_q, code_d;
  logic        err_q, err_d;
  seg_t        last_q, last_d;
  logic        emitted_q, emitted_d;

  code_t       lut_code;
  logic        lut_err;
  logic        stable;

  // cnt_q counts how long prev_q has been the sampled value, so the
  // pattern judged stable is prev_q.
  seg7_lut u_lut (
    .pattern (prev_q),
    .code    (lut_code),
    .err     (lut_err)
  );

  assign stable    = (cnt_q == STABLE);
  assign OUT_VALID = (state_q == PRESENT);
  assign CODE      = code_q;
  assign ERR       = err_q;

  // Sampling pipeline and saturating stability counter
  always_comb begin
    sample_d   = SEG_IN;
    prev_d     = sample_q;
    samp_vld_d = 1'b1;
    prev_vld_d = samp_vld_q;
    if (!samp_vld_q) begin
      cnt_d = 4'd0;
    end else if (!prev_vld_q || (sample_q != prev_q)) begin
      cnt_d = 4'd1;
    end else if (cnt_q == STABLE) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // TRACK/PRESENT next state and beat loading
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    err_d     = err_q;
    last_d    = last_q;
    emitted_d = emitted_q;
    case (state_q)
      TRACK: begin
        if (stable && (!emitted_q || (prev_q != last_q))) begin
          state_d   = PRESENT;
          code_d    = lut_code;
          err_d     = lut_err;
          last_d    = prev_q;
          emitted_d = 1'b1;
        end
      end
      PRESENT: begin
        if (OUT_READY) state_d = TRACK;
      end
      default: state_d = TRACK;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      sample_q   <= '0;
      prev_q     <= '0;
      samp_vld_q <= 1'b0;
      prev_vld_q <= 1'b0;
      cnt_q      <= 4'd0;
      state_q    <= TRACK;
      code_q     <= 4'h0;
      err_q      <= 1'b0;
      last_q     <= '0;
      emitted_q  <= 1'b0;
    end else begin
      sample_q   <= sample_d;
      prev_q     <= prev_d;
      samp_vld_q <= samp_vld_d;
      prev_vld_q <= prev_vld_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      code_q     <= code_d;
      err_q      <= err_d;
      last_q     <= last_d;
      emitted_q  <= emitted_d;
    end
  end

`ifdef SEG7_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       hs;

  assign hs        = (state_q == PRESENT) && OUT_READY;
  assign ERR_COUNT = err_cnt_q;

  // Count consumed error beats, saturating at 255
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (hs && err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error counter register
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) err_cnt_q <= 8'd0;
    else          err_cnt_q <= err_cnt_d;
  end
`else
  assign ERR_COUNT = 8'd0;
`endif

endmodule

// File: tb/tb_seg7_decoder.sv
// Self-checking bench for seg7_decoder: directed scenarios plus randomized
// traffic, all compared against a behavioural model built from the decode
// table and an input-history queue.
module tb_seg7_decoder;

  localparam int S = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = 7'b1111111;
  logic       ready = 1'b0;
  logic       out_valid;
  logic [3:0] code;
  logic       err;
  logic [7:0] err_count;

  always #10 clk = ~clk;

  seg7_decoder #(.STABLE_CYCLES(S)) dut (
    .CLOCK_50  (clk),
    .RESET_N   (rst_n),
    .SEG_IN    (seg_in),
    .OUT_READY (ready),
    .OUT_VALID (out_valid),
    .CODE      (code),
    .ERR       (err),
    .ERR_COUNT (err_count)
  );

  // ---------------- reference model ----------------
  logic [6:0] ref_pat [15] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b1000110, 7'b1000001,
                               7'b0010001, 7'b0001001, 7'b1111111};
  int         ref_code [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 13, 14, 15};

  function automatic void ref_decode(input logic [6:0] p, output logic [3:0] c,
                                     output logic e);
    c = 4'h0;
    e = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (ref_pat[i] == p) begin
        c = 4'(ref_code[i]);
        e = 1'b0;
      end
    end
  endfunction

  function automatic logic [6:0] rand_bad();
    logic [6:0] p;
    logic [3:0] c;
    logic       e;
    e = 1'b0;
    p = '0;
    while (!e) begin
      p = 7'($urandom_range(0, 127));
      ref_decode(p, c, e);
    end
    return p;
  endfunction

  // Input history since reset; a pattern is stable when it occupied the
  // S consecutive sample slots ending two inputs before the current edge.
  logic [6:0] hist [$];
  logic       m_valid = 1'b0, m_err = 1'b0, m_emitted = 1'b0;
  logic [3:0] m_code = 4'h0;
  logic [6:0] m_last = '0, m_pat;
  int         m_errcnt = 0;
  bit         m_stable;
  int         m_n;

  always @(posedge clk) begin
    if (!rst_n) begin
      hist.delete();
      m_valid   = 1'b0;
      m_code    = 4'h0;
      m_err     = 1'b0;
      m_emitted = 1'b0;
      m_errcnt  = 0;
    end else begin
      hist.push_back(seg_in);
      while (hist.size() > S + 2) void'(hist.pop_front());
      m_n      = hist.size();
      m_stable = (m_n >= S + 2);
      m_pat    = '0;
      if (m_stable) begin
        m_pat = hist[m_n-3];
        for (int k = m_n - 2 - S; k <= m_n - 3; k++)
          if (hist[k] != m_pat) m_stable = 1'b0;
      end
      if (m_valid) begin
        if (ready) begin
          m_valid = 1'b0;
`ifdef SEG7_ERRCNT_EN
          if (m_err && m_errcnt < 255) m_errcnt++;
`endif
        end
      end else if (m_stable && (!m_emitted || m_pat != m_last)) begin
        m_valid   = 1'b1;
        ref_decode(m_pat, m_code, m_err);
        m_last    = m_pat;
        m_emitted = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model updates on the rising edge, DUT is compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check("code", {28'd0, code}, {28'd0, m_code});
      check("err", {31'd0, err}, {31'd0, m_err});
    end
    check("err_count", {24'd0, err_count}, 32'(m_errcnt));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
  endtask

  int         beats;
  logic [3:0] beat_code;
  logic       beat_err;

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (out_valid && ready) begin
        beats++;
        beat_code = code;
        beat_err  = err;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_code", {28'd0, code}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_errcnt", {24'd0, err_count}, 32'd0);

    // Latency: valid after edge S+1, for one cycle with ready high
    seg_in = 7'b0100100;
    ready  = 1'b1;
    rst_n  = 1'b1;
    for (int k = 0; k <= S + 2; k++) begin
      tick();
      if (k == S) check("lat_early", {31'd0, out_valid}, 32'd0);
      if (k == S + 1) begin
        check("lat_valid", {31'd0, out_valid}, 32'd1);
        check("lat_code", {28'd0, code}, 32'd2);
        check("lat_err", {31'd0, err}, 32'd0);
      end
      if (k == S + 2) check("lat_one_cycle", {31'd0, out_valid}, 32'd0);
    end

    // Toggling every 2 cycles never stabilises, then one beat of 4
    beats = 0;
    for (int c = 0; c < 20; c++) begin
      seg_in = ((c / 2) % 2 == 1) ? 7'b0011001 : 7'b0110000;
      run(1);
    end
    check("toggle_beats", 32'(beats), 32'd0);
    seg_in = 7'b0011001;
    run(12);
    check("toggle_hold_beats", 32'(beats), 32'd1);
    check("toggle_hold_code", {28'd0, beat_code}, 32'd4);

    // Backpressure: beat 1 held while input moves to 8, then beat 8 follows
    ready  = 1'b0;
    seg_in = 7'b1111001;
    run(8);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_code", {28'd0, code}, 32'd1);
    seg_in = 7'b0000000;
    run(10);
    check("bp_hold_code", {28'd0, code}, 32'd1);
    ready = 1'b1;
    tick();
    check("bp_bubble", {31'd0, out_valid}, 32'd0);
    tick();
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    check("bp_next_code", {28'd0, code}, 32'd8);
    run(2);

    // Unrecognised pattern, then alternating error/valid beats
    beats  = 0;
    seg_in = 7'b0101010;
    run(8);
    check("bad_beats", 32'(beats), 32'd1);
    check("bad_code", {28'd0, beat_code}, 32'd0);
    check("bad_err", {31'd0, beat_err}, 32'd1);
    for (int p = 0; p < 300; p++) begin
      seg_in = rand_bad();
      run(S + 3);
      seg_in = ref_pat[$urandom_range(0, 14)];
      run(S + 3);
    end
`ifdef SEG7_ERRCNT_EN
    check("errcnt_sat", {24'd0, err_count}, 32'd255);
`else
    check("errcnt_off", {24'd0, err_count}, 32'd0);
`endif

    // Reset while a beat is pending, then the same pattern is re-emitted
    ready  = 1'b0;
    seg_in = 7'b0010010;
    run(S + 4);
    check("rp_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("rp_valid0", {31'd0, out_valid}, 32'd0);
    check("rp_code0", {28'd0, code}, 32'd0);
    check("rp_err0", {31'd0, err}, 32'd0);
    check("rp_errcnt0", {24'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k <= S + 1; k++) begin
      tick();
      if (k == S) check("rp_early", {31'd0, out_valid}, 32'd0);
      if (k == S + 1) begin
        check("rp_reemit", {31'd0, out_valid}, 32'd1);
        check("rp_reemit_code", {28'd0, code}, 32'd5);
      end
    end
    ready = 1'b1;
    run(1);

    // Long hold of one pattern gives exactly one beat
    beats  = 0;
    seg_in = 7'b1111111;
    run(100);
    check("hold_beats", 32'(beats), 32'd1);
    check("hold_code", {28'd0, beat_code}, 32'd15);

    // Randomized traffic with random hold lengths and backpressure
    for (int r = 0; r < 120; r++) begin
      if ($urandom_range(0, 4) == 0) seg_in = rand_bad();
      else seg_in = ref_pat[$urandom_range(0, 14)];
      for (int h = 0; h < int'($urandom_range(1, 8)); h++) begin
        ready = 1'(($urandom_range(0, 2)) != 0);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
